cdb_arbiter: RTL
================

# cdb_arbiter

Round-robin arbiter for the common data bus (CDB) in the out-of-order core. Up to `N_REQ` execution units (integer, multiply, divide, load/store) compete each cycle to broadcast a completed result. The arbiter grants one per cycle and drives the registered CDB broadcast that reservation stations and the register status table snoop. The same broadcast returns the freed tag to the dispatcher's tag FIFO through `cdb_tag_tf` / `cdb_tag_tf_valid`.

## Interface
- `N_REQ`, 4, number of requesting execution units; index 0 = integer, 1 = multiply, 2 = divide, 3 = load/store.
- `TAG_W`, 6, tag width; matches tag FIFO `DATA_WIDTH`.
- `DATA_W`, 32, result data width.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  request per unit; held with payload until granted.
- `tag_in`  in  N_REQ*TAG_W  packed tags; unit i occupies bits [i*TAG_W +: TAG_W].
- `data_in`  in  N_REQ*DATA_W  packed results; unit i occupies bits [i*DATA_W +: DATA_W].
- `grant`  out  N_REQ  one-hot or zero; combinational accept for this cycle.
- `cdb_stall`  in  1  when high, no grant is issued.
- `flush`  in  1  synchronous squash of the broadcast stage.
- `cdb_valid`  out  1  registered broadcast valid; also drives `cdb_tag_tf_valid`.
- `cdb_tag`  out  TAG_W  registered broadcast tag; also drives `cdb_tag_tf`.
- `cdb_data`  out  DATA_W  registered broadcast data.
- `cdb_src`  out  $clog2(N_REQ)  index of the unit that won the broadcast.

## Operation
- **State**
  - `rr_ptr` ($clog2(N_REQ) bits) holds the highest-priority index.
  - The output register holds `cdb_valid`, `cdb_tag`, `cdb_data` and `cdb_src`.
- **Arbitration**
  - Scan `req` starting at `rr_ptr`, ascending, wrapping modulo N_REQ.
  - The first set bit wins, and `grant` is one-hot on that bit.
  - `grant` is all zero when `req == 0`, when `cdb_stall == 1`, when `flush == 1`, or while `rst` is low.
- **On a grant to unit w at an edge**
  - `cdb_valid` <= 1.
  - `cdb_tag` <= tag slice w.
  - `cdb_data` <= data slice w.
  - `cdb_src` <= w.
  - `rr_ptr` <= (w+1) mod N_REQ.
- **With no grant at an edge**
  - `cdb_valid` <= 0.
  - `cdb_tag`, `cdb_data`, `cdb_src` hold their values.
  - `rr_ptr` holds.
- **Flush**
  - `cdb_valid` <= 0 at that edge, and no grant is issued.
  - `rr_ptr` holds.
  - A broadcast already valid in the flush cycle still completes in that cycle.
- **Requester handshake**
  - A requester samples `grant[i]` in the same cycle and drops or replaces its request at the next edge.
  - A request held without a grant is never lost.
  - Payload must be stable while `req[i]` is high and ungranted.
- **Fairness:** a continuously asserted request is granted within N_REQ grant cycles.
- **Single-unit case:** if only one unit requests, it is granted every unstalled cycle, giving back-to-back broadcasts.
- **Checker condition:** `cdb_valid` never exceeds one broadcast per cycle.

## Timing
- **Reset values** (while `rst` is low, independent of `clk`): `rr_ptr` = 0, `cdb_valid` = 0, `cdb_tag` = 0, `cdb_data` = 0, `cdb_src` = 0, `grant` = 0.
- **Latency:** a grant in cycle T gives `cdb_valid` high in cycle T+1, for exactly one cycle unless T+1 also grants.
- **Throughput:** 1 broadcast per cycle.
- **Combinational path:** `req` / `cdb_stall` / `flush` to `grant` is purely combinational, with no dependence on registered outputs other than `rr_ptr`.
- **Stall:** `cdb_stall` asserted in cycle T blocks the grant in T, so `cdb_valid` = 0 in T+1.
- **Reset mid-operation:** an in-flight broadcast is dropped, and `rr_ptr` returns to 0.
- **Pointer wrap:** when w = N_REQ-1, `rr_ptr` becomes 0.

## Test plan
- **Reset:** hold `rst` low with `req` = 4'b1111.
  - Required: `grant` = 0 and `cdb_valid` = 0.
  - Release reset. Required: the first grant = 4'b0001 and `cdb_src` = 0 one cycle later.
- **Rotation:** `req` = 4'b1111 held for 8 cycles.
  - Required grant sequence: 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000.
  - Required: `cdb_tag` follows each tag slice one cycle later, and `cdb_valid` is continuously high.
- **Single requester:** unit 2 only, tags 6'd5, 6'd9, 6'd17 on consecutive cycles.
  - Required: `cdb_tag` = 5, 9, 17 on consecutive cycles, and `cdb_src` = 2 for all three.
- **Stall:** `req` = 4'b1010 with `cdb_stall` high for 3 cycles, then low.
  - Required: `grant` = 0 and `cdb_valid` = 0 while stalled.
  - Then grants 0010 followed by 1000, with payloads unchanged.
- **Flush:** grant unit 1 in cycle T, then assert `flush` in T+1 with `req` = 4'b0001.
  - Required: `cdb_valid` high in T+1, low in T+2.
  - Required: unit 0 is granted in T+2 after `flush` drops, with `rr_ptr` = 2 preserved, so 0 wins only because it is the sole requester.
- **Async reset mid-stream:** pulse `rst` low between edges while `cdb_valid` = 1.
  - Required: `cdb_valid` = 0 immediately, and arbitration restarts from index 0.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Bundle of request-side and broadcast-side signals for the CDB arbiter.
// The arbiter connects through the master modport; requesters and snoopers through slave.
interface cdb_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
);
    localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*TAG_W-1:0]  tag_in;
    logic [N_REQ*DATA_W-1:0] data_in;
    logic [N_REQ-1:0]        grant;
    logic                    cdb_stall;
    logic                    flush;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_data;
    logic [SRC_W-1:0]        cdb_src;
    logic [TAG_W-1:0]        cdb_tag_tf;
    logic                    cdb_tag_tf_valid;

    modport master (
        input  req, tag_in, data_in, cdb_stall, flush,
        output grant, cdb_valid, cdb_tag, cdb_data, cdb_src, cdb_tag_tf, cdb_tag_tf_valid
    );

    modport slave (
        output req, tag_in, data_in, cdb_stall, flush,
        input  grant, cdb_valid, cdb_tag, cdb_data, cdb_src, cdb_tag_tf, cdb_tag_tf_valid
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: one combinational grant per cycle and a
// registered broadcast of the winner's tag/data that also returns the tag to the tag FIFO.
module cdb_arbiter #(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    cdb_arbiter_if.master  bus
);
    localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

    logic              win_found;
    logic [SRC_W-1:0]  win_idx;
    logic [SRC_W:0]    cand;
    logic              grant_ok;
    logic [N_REQ-1:0]  grant_vec;
    logic [TAG_W-1:0]  win_tag;
    logic [DATA_W-1:0] win_data;

    // Scan from rr_ptr upward with wrap; the extra bit of cand absorbs the carry before wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
            if (cand >= (SRC_W+1)'(N_REQ)) begin
                cand = cand - (SRC_W+1)'(N_REQ);
            end
            if (!win_found && bus.req[cand[SRC_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[SRC_W-1:0];
            end
        end
    end

    assign grant_ok = win_found & ~bus.cdb_stall & ~bus.flush & rst_n;

    always_comb begin
        grant_vec = '0;
        win_tag   = '0;
        win_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == SRC_W'(i)) begin
                grant_vec[i] = grant_ok;
                win_tag      = bus.tag_in[i*TAG_W +: TAG_W];
                win_data     = bus.data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // Without a grant the payload registers keep the last broadcast; only valid drops.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = grant_ok;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        if (grant_ok) begin
            cdb_tag_d  = win_tag;
            cdb_data_d = win_data;
            cdb_src_d  = win_idx;
            rr_ptr_d   = (win_idx == SRC_W'(N_REQ-1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign bus.grant            = grant_vec;
    assign bus.cdb_valid        = cdb_valid_q;
    assign bus.cdb_tag          = cdb_tag_q;
    assign bus.cdb_data         = cdb_data_q;
    assign bus.cdb_src          = cdb_src_q;
    assign bus.cdb_tag_tf       = cdb_tag_q;
    assign bus.cdb_tag_tf_valid = cdb_valid_q;
endmodule
